// File: rtl/game_state_ctl.sv
// Screen sequencer for the two-player game: START menu, LEVEL_1 play, FINISH screen.
// Frame ticks come from the vsync rising edge. Clicks are press/release pairs on m_left.
package state_pkg;
  typedef enum logic [1:0] {
    START   = 2'd0,
    LEVEL_1 = 2'd1,
    FINISH  = 2'd2
  } g_state;
endpackage

module game_state_ctl
  import state_pkg::*;
#(
  parameter logic [11:0] START_X0      = 12'd350,
  parameter logic [11:0] START_X1      = 12'd450,
  parameter logic [11:0] START_Y0      = 12'd400,
  parameter logic [11:0] START_Y1      = 12'd450,
  parameter logic [11:0] EXIT_X0       = 12'd700,
  parameter logic [11:0] EXIT_X1       = 12'd780,
  parameter logic [11:0] EXIT_Y0       = 12'd500,
  parameter logic [11:0] EXIT_Y1       = 12'd560,
  parameter logic [7:0]  EXIT_FRAMES   = 8'd30,
  parameter logic [8:0]  FINISH_FRAMES = 9'd180
) (
  input  logic        clk_40,
  input  logic        rst,
  input  logic        vsync,
  input  logic        m_left,
  input  logic [11:0] xpos_mouse,
  input  logic [11:0] ypos_mouse,
  input  logic [11:0] xpos_player1,
  input  logic [11:0] ypos_player1,
  input  logic [11:0] xpos_player2,
  input  logic [11:0] ypos_player2,
  output g_state      game_state,
  output logic        level_init,
  output logic        finish_ready
);

  g_state      state_q, state_d;
  logic        vsync_q, vsync_qq;
  logic        m_left_q;
  logic        armed_q, armed_d;
  logic [7:0]  exit_cnt_q, exit_cnt_d;
  logic [8:0]  fin_cnt_q, fin_cnt_d;
  logic        level_init_q, level_init_d;
  logic        finish_ready_q, finish_ready_d;

  logic        frame_tick;
  logic        press;
  logic        click;
  logic        in_start;
  logic        p1_in_exit;
  logic        p2_in_exit;
  logic [7:0]  exit_nxt;

  assign frame_tick = vsync_q & ~vsync_qq;
  assign press      = m_left & ~m_left_q;
  assign click      = ~m_left & m_left_q;

  assign in_start   = (xpos_mouse >= START_X0) && (xpos_mouse <= START_X1) &&
                      (ypos_mouse >= START_Y0) && (ypos_mouse <= START_Y1);
  assign p1_in_exit = (xpos_player1 >= EXIT_X0) && (xpos_player1 <= EXIT_X1) &&
                      (ypos_player1 >= EXIT_Y0) && (ypos_player1 <= EXIT_Y1);
  assign p2_in_exit = (xpos_player2 >= EXIT_X0) && (xpos_player2 <= EXIT_X1) &&
                      (ypos_player2 >= EXIT_Y0) && (ypos_player2 <= EXIT_Y1);

  always_ff @(posedge clk_40) begin
    if (rst) begin
      state_q        <= START;
      vsync_q        <= 1'b0;
      vsync_qq       <= 1'b0;
      m_left_q       <= 1'b0;
      armed_q        <= 1'b0;
      exit_cnt_q     <= 8'd0;
      fin_cnt_q      <= 9'd0;
      level_init_q   <= 1'b0;
      finish_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= vsync;
      vsync_qq       <= vsync_q;
      m_left_q       <= m_left;
      armed_q        <= armed_d;
      exit_cnt_q     <= exit_cnt_d;
      fin_cnt_q      <= fin_cnt_d;
      level_init_q   <= level_init_d;
      finish_ready_q <= finish_ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    exit_cnt_d   = exit_cnt_q;
    fin_cnt_d    = fin_cnt_q;
    level_init_d = 1'b0;
    exit_nxt     = (exit_cnt_q == 8'hFF) ? 8'hFF : exit_cnt_q + 8'd1;

    unique case (state_q)
      START: begin
        exit_cnt_d = 8'd0;
        fin_cnt_d  = 9'd0;
        // The mouse must be inside the button both at press and at release.
        if (press) begin
          armed_d = in_start;
        end else if (click) begin
          armed_d = 1'b0;
          if (armed_q && in_start) begin
            state_d      = LEVEL_1;
            level_init_d = 1'b1;
          end
        end
      end

      LEVEL_1: begin
        armed_d   = 1'b0;
        fin_cnt_d = 9'd0;
        if (frame_tick) begin
          if (p1_in_exit && p2_in_exit) begin
            if (exit_nxt >= EXIT_FRAMES) begin
              state_d    = FINISH;
              exit_cnt_d = 8'd0;
            end else begin
              exit_cnt_d = exit_nxt;
            end
          end else begin
            exit_cnt_d = 8'd0;
          end
        end
      end

      FINISH: begin
        exit_cnt_d = 8'd0;
        // Only a press made after the screen became ready may return to START.
        if (press) begin
          armed_d = finish_ready_q;
        end
        if (click && armed_q) begin
          state_d   = START;
          armed_d   = 1'b0;
          fin_cnt_d = 9'd0;
        end else begin
          if (click) begin
            armed_d = 1'b0;
          end
          if (frame_tick && (fin_cnt_q != 9'h1FF)) begin
            fin_cnt_d = fin_cnt_q + 9'd1;
          end
        end
      end

      default: begin
        state_d    = START;
        armed_d    = 1'b0;
        exit_cnt_d = 8'd0;
        fin_cnt_d  = 9'd0;
      end
    endcase

    finish_ready_d = (state_d == FINISH) && (fin_cnt_d >= FINISH_FRAMES);
  end

  assign game_state   = state_q;
  assign level_init   = level_init_q;
  assign finish_ready = finish_ready_q;

endmodule

// File: tb/tb_game_state_ctl.sv
// Bench for game_state_ctl: directed scenarios plus randomized play, all checked
// cycle by cycle against a screen-level reference model.
module tb_game_state_ctl;
  import state_pkg::*;

  localparam int EXITF = 3;
  localparam int FINF  = 4;

  localparam int M_START = 0;
  localparam int M_LEVEL = 1;
  localparam int M_FIN   = 2;

  logic        clk_40 = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        m_left = 1'b0;
  logic [11:0] xpos_mouse = 12'd0;
  logic [11:0] ypos_mouse = 12'd0;
  logic [11:0] xpos_player1 = 12'd0;
  logic [11:0] ypos_player1 = 12'd0;
  logic [11:0] xpos_player2 = 12'd0;
  logic [11:0] ypos_player2 = 12'd0;
  g_state      game_state;
  logic        level_init;
  logic        finish_ready;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int md = M_START;
  int m_exit = 0;
  int m_fin = 0;
  bit m_hold_ok = 0;
  bit e_lvl = 0;
  bit e_rdy = 0;
  bit h_vs1 = 0, h_vs2 = 0, h_ml = 0;

  game_state_ctl #(
    .EXIT_FRAMES  (8'(EXITF)),
    .FINISH_FRAMES(9'(FINF))
  ) dut (
    .clk_40      (clk_40),
    .rst         (rst),
    .vsync       (vsync),
    .m_left      (m_left),
    .xpos_mouse  (xpos_mouse),
    .ypos_mouse  (ypos_mouse),
    .xpos_player1(xpos_player1),
    .ypos_player1(ypos_player1),
    .xpos_player2(xpos_player2),
    .ypos_player2(ypos_player2),
    .game_state  (game_state),
    .level_init  (level_init),
    .finish_ready(finish_ready)
  );

  always #12.5 clk_40 = ~clk_40;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_box(input int x, input int y, input int x0, input int x1,
                                input int y0, input int y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  function automatic int mode_code(input int m);
    case (m)
      M_LEVEL: return int'(LEVEL_1);
      M_FIN:   return int'(FINISH);
      default: return int'(START);
    endcase
  endfunction

  task automatic model_step();
    bit tick, pressed, released, on_btn, both_out;
    if (rst) begin
      md = M_START; m_exit = 0; m_fin = 0; m_hold_ok = 0;
      e_lvl = 0; e_rdy = 0; h_vs1 = 0; h_vs2 = 0; h_ml = 0;
      return;
    end
    tick     = h_vs1 && !h_vs2;
    pressed  = m_left && !h_ml;
    released = !m_left && h_ml;
    h_vs2 = h_vs1; h_vs1 = vsync; h_ml = m_left;
    on_btn   = in_box(xpos_mouse, ypos_mouse, 350, 450, 400, 450);
    both_out = !(in_box(xpos_player1, ypos_player1, 700, 780, 500, 560) &&
                 in_box(xpos_player2, ypos_player2, 700, 780, 500, 560));
    e_lvl = 0;
    if (md == M_START) begin
      if (pressed) m_hold_ok = on_btn;
      else if (released) begin
        if (m_hold_ok && on_btn) begin
          md = M_LEVEL;
          e_lvl = 1;
        end
        m_hold_ok = 0;
      end
    end else if (md == M_LEVEL) begin
      if (tick) begin
        m_exit = both_out ? 0 : ((m_exit + 1 > 255) ? 255 : m_exit + 1);
        if (m_exit >= EXITF) begin
          md = M_FIN;
          m_exit = 0;
          m_fin = 0;
        end
      end
    end else begin
      if (pressed) m_hold_ok = e_rdy;
      if (released && m_hold_ok) begin
        md = M_START;
        m_fin = 0;
        m_hold_ok = 0;
      end else begin
        if (released) m_hold_ok = 0;
        if (tick && m_fin < 511) m_fin++;
      end
    end
    e_rdy = (md == M_FIN) && (m_fin >= FINF);
  endtask

  task automatic cyc();
    @(posedge clk_40);
    model_step();
    #1;
    chk("game_state", int'(game_state), mode_code(md));
    chk("level_init", int'(level_init), int'(e_lvl));
    chk("finish_ready", int'(finish_ready), int'(e_rdy));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1; cycles(2);
    vsync = 1'b0; cycles(3);
  endtask

  task automatic click_at(input int x, input int y);
    xpos_mouse = 12'(x); ypos_mouse = 12'(y);
    m_left = 1'b1; cycles(3);
    m_left = 1'b0; cyc();
  endtask

  task automatic players_at(input int x1, input int y1, input int x2, input int y2);
    xpos_player1 = 12'(x1); ypos_player1 = 12'(y1);
    xpos_player2 = 12'(x2); ypos_player2 = 12'(y2);
  endtask

  function automatic int pick(input int a, input int b, input int c, input int d, input int e);
    case ($urandom_range(0, 4))
      0: return a;
      1: return b;
      2: return c;
      3: return d;
      default: return e;
    endcase
  endfunction

  int ticks_seen;
  int vs_left;

  initial begin
    // reset state
    rst = 1'b1; cycles(3);
    chk("rst_state", int'(game_state), int'(START));
    chk("rst_level_init", int'(level_init), 0);
    chk("rst_finish_ready", int'(finish_ready), 0);
    rst = 1'b0; cycles(2);

    // start button: 5-cycle hold at (400,420)
    xpos_mouse = 12'd400; ypos_mouse = 12'd420;
    m_left = 1'b1; cycles(5);
    m_left = 1'b0; cyc();
    chk("start_to_level", int'(game_state), int'(LEVEL_1));
    chk("level_init_pulse", int'(level_init), 1);
    cyc();
    chk("level_init_one_cycle", int'(level_init), 0);

    // exit region corner; player2 steps out after two ticks
    players_at(700, 560, 700, 560);
    pulse_vsync(); pulse_vsync();
    players_at(700, 560, 781, 560);
    pulse_vsync();
    chk("exit_cnt_cleared", int'(dut.exit_cnt_q), 0);
    chk("stay_level", int'(game_state), int'(LEVEL_1));
    players_at(700, 560, 780, 500);
    pulse_vsync(); pulse_vsync();
    chk("still_level_2ticks", int'(game_state), int'(LEVEL_1));
    pulse_vsync();
    chk("level_to_finish", int'(game_state), int'(FINISH));

    // finish screen: early click ignored, press straddling readiness ignored
    pulse_vsync(); pulse_vsync();
    click_at(100, 100);
    chk("early_click_ignored", int'(game_state), int'(FINISH));
    pulse_vsync();
    m_left = 1'b1; cyc();
    pulse_vsync();
    chk("ready_after_4", int'(finish_ready), 1);
    m_left = 1'b0; cyc();
    chk("straddle_click_ignored", int'(game_state), int'(FINISH));
    click_at(100, 100);
    chk("finish_to_start", int'(game_state), int'(START));
    chk("ready_cleared", int'(finish_ready), 0);

    // reset mid-FINISH with fin_cnt=3
    click_at(350, 450);
    players_at(780, 500, 700, 500);
    pulse_vsync(); pulse_vsync(); pulse_vsync();
    pulse_vsync(); pulse_vsync(); pulse_vsync();
    chk("fin_cnt_3", int'(dut.fin_cnt_q), 3);
    rst = 1'b1; cyc();
    rst = 1'b0;
    chk("rst_finish_state", int'(game_state), int'(START));
    chk("rst_finish_ready", int'(finish_ready), 0);
    chk("rst_fin_cnt", int'(dut.fin_cnt_q), 0);
    chk("rst_no_level_init", int'(level_init), 0);
    cycles(2);

    // press outside, release inside
    xpos_mouse = 12'd340; ypos_mouse = 12'd420;
    m_left = 1'b1; cyc();
    chk("armed_outside", int'(dut.armed_q), 0);
    cycles(2);
    xpos_mouse = 12'd400;
    cyc();
    m_left = 1'b0; cyc();
    chk("outside_press_stays", int'(game_state), int'(START));

    // vsync held high for 1000 cycles
    ticks_seen = 0;
    vsync = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (dut.frame_tick) ticks_seen++;
    end
    vsync = 1'b0; cycles(3);
    chk("single_frame_tick", ticks_seen, 1);

    // randomized play
    vs_left = 5;
    for (int i = 0; i < 20000; i++) begin
      rst = ($urandom_range(0, 1999) == 0);
      if (--vs_left <= 0) begin
        vsync = ~vsync;
        vs_left = vsync ? $urandom_range(1, 4) : $urandom_range(2, 8);
      end
      if ($urandom_range(0, 5) == 0) m_left = ~m_left;
      if ($urandom_range(0, 7) == 0) begin
        xpos_mouse = 12'(pick(349, 350, 400, 450, 451));
        ypos_mouse = 12'(pick(399, 400, 420, 450, 451));
      end
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 3) != 0)
          players_at(pick(700, 700, 740, 780, 780), pick(500, 500, 530, 560, 560),
                     pick(700, 720, 740, 760, 780), pick(500, 520, 530, 550, 560));
        else
          players_at(pick(699, 700, 740, 781, 4095), pick(499, 500, 530, 561, 0),
                     pick(699, 700, 740, 781, 0), pick(499, 500, 530, 561, 4095));
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/game_state_ctl.md
GAME_STATE_CTL -- requirements
Module: game_state_ctl

Interface
REQ-001 SHALL have parameter START_X0, default 350, meaning start-button left edge (pixels, inclusive).
REQ-002 SHALL have parameter START_X1, default 450, meaning start-button right edge (inclusive).
REQ-003 SHALL have parameter START_Y0, default 400, meaning start-button top edge (inclusive).
REQ-004 SHALL have parameter START_Y1, default 450, meaning start-button bottom edge (inclusive).
REQ-005 SHALL have parameters EXIT_X0/EXIT_X1/EXIT_Y0/EXIT_Y1, defaults 700/780/500/560, meaning level-exit region (inclusive).
REQ-006 SHALL have parameter EXIT_FRAMES, default 30, meaning consecutive frames both players must stay in the exit region.
REQ-007 SHALL have parameter FINISH_FRAMES, default 180, meaning minimum frames in FINISH before a click is accepted.
REQ-008 SHALL have port clk_40, input, 1, 40 MHz pixel clock.
REQ-009 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-010 SHALL have port vsync, input, 1, VGA vertical sync from the timing chain; frame reference.
REQ-011 SHALL have port m_left, input, 1, left mouse button level, already synchronous to clk_40.
REQ-012 SHALL have ports xpos_mouse and ypos_mouse, input, 12 each, mouse pointer position.
REQ-013 SHALL have ports xpos_player1, ypos_player1, xpos_player2 and ypos_player2, input, 12 each, player positions.
REQ-014 SHALL have port game_state, output, g_state (state_pkg), current screen select: START, LEVEL_1 or FINISH.
REQ-015 SHALL have port level_init, output, 1, one-cycle pulse on entry to LEVEL_1, used to reload player and rect controllers.
REQ-016 SHALL have port finish_ready, output, 1, high in FINISH once FINISH_FRAMES has elapsed.

Function
REQ-017 SHALL generate frame_tick, a one-cycle pulse in the cycle after vsync is first sampled 1 following a sampled 0.
REQ-018 SHALL detect a click as m_left sampled 1 then sampled 0, with the release cycle producing a one-cycle click event.
REQ-019 SHALL register all outputs; game_state SHALL change in the cycle after the transition condition is sampled.
REQ-020 SHALL evaluate region tests as unsigned inclusive compares on all four edges.
REQ-021 START: on press with the mouse inside the start region, arm; on release, go to LEVEL_1 only if armed and the mouse is still inside the region, else disarm.
REQ-022 START: a press outside the region SHALL NOT arm, even if the release occurs inside.
REQ-023 On the START->LEVEL_1 transition, level_init SHALL be 1 for exactly the first cycle game_state==LEVEL_1.
REQ-024 LEVEL_1: on each frame_tick, if both players are inside the exit region, increment exit_cnt (8-bit, saturating at 255); otherwise clear exit_cnt to 0.
REQ-025 LEVEL_1: when exit_cnt reaches EXIT_FRAMES, SHALL go to FINISH and clear exit_cnt.
REQ-026 LEVEL_1: mouse clicks SHALL be ignored.
REQ-027 FINISH: on each frame_tick, increment fin_cnt (9-bit, saturating); finish_ready = (fin_cnt >= FINISH_FRAMES).
REQ-028 FINISH: a click whose press occurred while finish_ready==1 SHALL go to START; presses before finish_ready SHALL be discarded, including one released after finish_ready.
REQ-029 Entering START SHALL clear fin_cnt, finish_ready and the armed flag.
REQ-030 An illegal or unknown internal state SHALL recover to START on the next cycle.
REQ-031 A frame_tick and a click in the same cycle SHALL both be applied; the click-driven transition takes priority in START and FINISH.

Reset
REQ-032 While rst==1 at a clk_40 edge: game_state=START, level_init=0, finish_ready=0, exit_cnt=0, fin_cnt=0, armed=0, vsync and m_left history registers=0.
REQ-033 Reset asserted mid-LEVEL_1 or mid-FINISH SHALL return to START on the next edge with no level_init pulse.

Verification
REQ-034 Mouse at (400,420), m_left 1 for 5 cycles then 0 -> game_state=LEVEL_1 one cycle after the release sample; level_init high for 1 cycle.
REQ-035 Press at (340,420), release at (400,420) -> game_state remains START; armed never set.
REQ-036 In LEVEL_1 with EXIT_FRAMES=3: both players at (700,560) for 3 vsync pulses -> FINISH after the 3rd frame_tick; player2 moved to (781,560) after 2 ticks -> exit_cnt=0, state stays LEVEL_1.
REQ-037 In FINISH with FINISH_FRAMES=4: click after 2 ticks -> ignored; click pressed after the 4th tick -> finish_ready=1 first, then START on the release.
REQ-038 rst pulsed for 1 cycle while in FINISH with fin_cnt=3 -> next cycle game_state=START, finish_ready=0, fin_cnt=0.
REQ-039 vsync held high for 1000 cycles -> exactly one frame_tick.
